mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Access controller placed between the execute/ALU stage and dmemory32; drives dmemory32's memWrite, addr and writeData and consumes its readData.
- Adds byte and halfword loads and stores on top of the word-only data memory; sub-word stores use a read-modify-write sequence.
- Stalls the pipeline with a ready/valid handshake and returns extended load data.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  high when state==IDLE (combinational); request transfers when req_valid && req_ready.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads when 1.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: load data valid or store complete.
- resp_rdata  out  32  extended load data; holds until the next load completes.
- misalign_err  out  1  one-cycle error pulse.
- mem_write  out  1  to dmemory32 memWrite.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits[1:0]=00).
- mem_wdata  out  32  to dmemory32 writeData.
- mem_rdata  in  32  from dmemory32 readData; valid the cycle after mem_addr is presented.

Behaviour:
- Reset: state=IDLE. resp_valid=0, resp_rdata=0, misalign_err=0, mem_write=0, mem_addr=0, mem_wdata=0. All memory-side outputs are registered.
- Lane mapping: little-endian. Byte k = bits[8k+7:8k], with k=addr[1:0]. A half at addr[1]=h occupies bits[16h+15:16h].
- States:
  - IDLE: on transfer, latch the request and set mem_addr. Word store goes to WRITE with mem_wdata=req_wdata. All other requests go to READ.
  - READ: mem_write=0; address is presented to memory. Next state CAPT.
  - CAPT: mem_rdata is valid.
    - Load: register the extracted and extended lane into resp_rdata, then go to IDLE with resp_valid=1 in the next cycle.
    - Sub-word store: merge req_wdata[7:0] or [15:0] into the addressed lane, keep the other lanes, register the result into mem_wdata, then go to WRITE.
  - WRITE: mem_write=1 for exactly this cycle. Then go to IDLE with resp_valid=1.
- Latency (accept cycle = 0), measured to resp_valid:
  - Load: 3 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 4 cycles.
- A new request may transfer in the same cycle resp_valid is high, because state is IDLE.
- Extension:
  - Signed: replicate the MSB of the lane.
  - Unsigned: zero-fill.
  - Word loads ignore req_unsigned.
- Illegal size (11): handled as a misaligned access.
- Reset mid-operation returns to IDLE at once and mem_write drops asynchronously. A store aborted before WRITE never modifies memory, and no resp_valid is issued.
- req_* inputs are sampled only on transfer; changes afterward are ignored.

Optional Feature:
- MISALIGN_CHECK_EN defined:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11 is rejected in IDLE. No memory access occurs.
  - misalign_err pulses in cycle 1; no resp_valid; state stays IDLE.
- Undefined:
  - Offending low address bits are ignored: half is aligned down to even, word to a multiple of 4. Size 11 is handled as word.
  - misalign_err is tied to 0.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - state enum IDLE/READ/CAPT/WRITE;
  - the lane-width constant.
- One combinational sub-module, mem_lane_align:
  - inputs: word, offset, size, unsigned flag, store data;
  - outputs: extended load value and merged store word.
- The FSM stays in mem_access_ctrl.

Test Plan:
- Preload word 0x10=0xA00000F5. LB 0x10 → resp_rdata=0xFFFFFFF5, resp_valid in cycle 3, mem_write never high.
- LBU 0x10 → 0x000000F5. LH 0x12 → 0xFFFFA000. LHU 0x12 → 0x0000A000.
- SB 0x11 with wdata 0x1234563C → one mem_write cycle (cycle 3), mem_addr=0x10, mem_wdata=0xA0003CF5; a following LW 0x10 returns 0xA0003CF5.
- SW 0x14 with wdata 0xDEADBEEF → mem_write only in cycle 1, resp_valid in cycle 2. Back-to-back LW issued in the resp cycle is accepted with no bubble.
- With MISALIGN_CHECK_EN, LW 0x12 → misalign_err=1 in cycle 1, no resp_valid, no memory access. Without it → reads word 0x10.
- Assert reset while state=CAPT of an SH 0x10 → outputs return to reset values immediately and word 0x10 is unchanged.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size
// encodings, controller state encoding and the byte-lane width.
package mem_access_pkg;

    localparam int LANE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CAPT  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge
// for sub-word stores.
// Ports: word (memory word), offset (byte offset, already aligned),
//   size, uns (zero-extend), store_data (right-justified),
//   load_val (extended load), merged (word with store lane inserted).
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] store_data,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [LANE_W-1:0]   byte_lane;
    logic [2*LANE_W-1:0] half_lane;

    always_comb begin
        byte_lane = word[{offset, 3'b000} +: LANE_W];
        half_lane = offset[1] ? word[31:16] : word[15:0];
        load_val  = word;
        merged    = store_data;
        unique case (size)
            SZ_BYTE: begin
                load_val = uns ? {24'd0, byte_lane}
                               : {{24{byte_lane[7]}}, byte_lane};
                merged = word;
                merged[{offset, 3'b000} +: LANE_W] = store_data[7:0];
            end
            SZ_HALF: begin
                load_val = uns ? {16'd0, half_lane}
                               : {{16{half_lane[15]}}, half_lane};
                merged = word;
                merged[{offset[1], 4'b0000} +: 2*LANE_W] = store_data[15:0];
            end
            default: begin
                load_val = word;
                merged   = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of word-only dmemory32.
// Sub-word stores are done as read-modify-write.
// Request side: req_valid/req_ready handshake, req_write, req_size,
//   req_unsigned, req_addr, req_wdata; resp_valid, resp_rdata,
//   misalign_err. Memory side: mem_write, mem_addr, mem_wdata,
//   mem_rdata (valid the cycle after mem_addr).
// Build option: MISALIGN_CHECK_EN rejects misaligned/illegal requests;
//   otherwise low address bits are ignored and size 11 acts as word.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  misalign_err,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    state_t      state;
    state_t      state_n;
    logic        q_write;
    logic [1:0]  q_size;
    logic        q_uns;
    logic [1:0]  q_off;
    logic [31:0] q_wdata;

    logic        xfer;
    logic        bad;
    logic [1:0]  eff_size;
    logic [1:0]  eff_off;
    logic        word_store;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);
    assign xfer      = req_valid && req_ready;

    // Illegal size behaves as a word; offsets are forced to lane alignment.
    always_comb begin
        eff_size = (req_size == SZ_ILL) ? SZ_WORD : req_size;
        eff_off  = 2'b00;
        unique case (eff_size)
            SZ_BYTE: eff_off = req_addr[1:0];
            SZ_HALF: eff_off = {req_addr[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign bad = (req_size == SZ_ILL)
              || (req_size == SZ_HALF && req_addr[0])
              || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif

    assign word_store = req_write && (eff_size == SZ_WORD);

    mem_lane_align u_align (
        .word       (mem_rdata),
        .offset     (q_off),
        .size       (q_size),
        .uns        (q_uns),
        .store_data (q_wdata),
        .load_val   (load_val),
        .merged     (merged)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (xfer && !bad) state_n = word_store ? WRITE : READ;
            READ:  state_n = CAPT;
            CAPT:  state_n = q_write ? WRITE : IDLE;
            WRITE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            misalign_err <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            q_write      <= 1'b0;
            q_size       <= SZ_BYTE;
            q_uns        <= 1'b0;
            q_off        <= 2'b00;
            q_wdata      <= 32'd0;
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            mem_write    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer && bad) begin
                        misalign_err <= 1'b1;
                    end else if (xfer) begin
                        q_write  <= req_write;
                        q_size   <= eff_size;
                        q_uns    <= req_unsigned;
                        q_off    <= eff_off;
                        q_wdata  <= req_wdata;
                        mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (word_store) begin
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                CAPT: begin
                    if (q_write) begin
                        mem_wdata <= merged;
                        mem_write <= 1'b1;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                    end
                end
                WRITE: resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan cases
// plus randomized requests against a behavioural timeline model.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clock = ~clock;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // dmemory32 stand-in: synchronous read, 16 words, preload port.
    logic [31:0] dmem [16];
    logic        pl_we = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_d = 32'd0;

    always @(posedge clock) begin
        if (pl_we) dmem[pl_idx] <= pl_d;
        else if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[5:2]];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Reference model state.
    logic [31:0] ref_mem [16];
    bit          exp_rv  [int];
    bit          exp_mw  [int];
    bit          exp_err [int];
    logic [31:0] exp_ma  [int];
    logic [31:0] exp_md  [int];
    logic [31:0] exp_rd  [int];
    logic [31:0] cur_rd = 32'd0;
    int          busy_until = 0;
    bit          checking = 1'b0;

    function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] sz,
                                           logic uns, logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] w, logic [1:0] sz,
                                            logic [31:0] a, logic [31:0] d);
        logic [31:0] mask;
        if (sz == 2'b00) begin
            mask = 32'hFF << (8 * a[1:0]);
            return (w & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
        end else if (sz == 2'b01) begin
            mask = 32'hFFFF << (16 * a[1]);
            return (w & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
        end
        return d;
    endfunction

    function automatic bit m_misaligned(logic [1:0] sz, logic [31:0] a);
`ifdef MISALIGN_CHECK_EN
        return (sz == 2'b11) || (sz == 2'b01 && a[0])
            || (sz == 2'b10 && a[1:0] != 2'b00);
`else
        return (sz == 2'b11) && (a[0] && !a[0]);
`endif
    endfunction

    always @(negedge clock) begin
        if (checking && !reset) begin
            if (exp_rd.exists(cyc)) cur_rd = exp_rd[cyc];
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv.exists(cyc)));
            chk("mem_write", 32'(mem_write), 32'(exp_mw.exists(cyc)));
            chk("misalign_err", 32'(misalign_err), 32'(exp_err.exists(cyc)));
            chk("resp_rdata", resp_rdata, cur_rd);
            chk("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
            if (exp_mw.exists(cyc)) begin
                chk("mem_addr", mem_addr, exp_ma[cyc]);
                chk("mem_wdata", mem_wdata, exp_md[cyc]);
            end
        end
    end

    // Present one request in the current cycle (called at negedge+2).
    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit wait_done);
        int n;
        int idx;
        int lat;
        logic [31:0] nw;
        n   = cyc;
        idx = int'(a[5:2]);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        if (m_misaligned(sz, a)) begin
            exp_err[n+1] = 1'b1;
            lat = 1;
        end else if (!wr) begin
            exp_rd[n+3] = m_load(ref_mem[idx], sz, uns, a);
            exp_rv[n+3] = 1'b1;
            lat = 3;
        end else if (sz[1]) begin
            ref_mem[idx] = d;
            exp_mw[n+1]  = 1'b1;
            exp_ma[n+1]  = {a[31:2], 2'b00};
            exp_md[n+1]  = d;
            exp_rv[n+2]  = 1'b1;
            lat = 2;
        end else begin
            nw = m_store(ref_mem[idx], sz, a, d);
            ref_mem[idx] = nw;
            exp_mw[n+3]  = 1'b1;
            exp_ma[n+3]  = {a[31:2], 2'b00};
            exp_md[n+3]  = nw;
            exp_rv[n+4]  = 1'b1;
            lat = 4;
        end
        busy_until = m_misaligned(sz, a) ? n : n + lat;
        @(negedge clock); #2;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (wait_done)
            for (int i = 1; i < lat; i++) begin
                @(negedge clock); #2;
            end
    endtask

    logic [31:0] saved;

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            pl_idx = 4'(i);
            pl_d   = (i == 4) ? 32'hA000_00F5 : $urandom;
            ref_mem[i] = pl_d;
            pl_we  = 1'b1;
        end
        @(negedge clock);
        pl_we = 1'b0;
        #2 reset = 1'b0;
        checking = 1'b1;

        chk("pin_lb", m_load(32'hA000_00F5, 2'b00, 1'b0, 32'h10), 32'hFFFF_FFF5);
        chk("pin_lh", m_load(32'hA000_00F5, 2'b01, 1'b0, 32'h12), 32'hFFFF_A000);
        chk("pin_sb", m_store(32'hA000_00F5, 2'b00, 32'h11, 32'h1234_563C),
            32'hA000_3CF5);

        @(negedge clock); #2;
        issue(0, 2'b00, 0, 32'h10, 32'd0, 1);
        chk("lb_data", resp_rdata, 32'hFFFF_FFF5);
        chk("lb_valid", 32'(resp_valid), 32'd1);
        issue(0, 2'b00, 1, 32'h10, 32'd0, 1);
        chk("lbu_data", resp_rdata, 32'h0000_00F5);
        issue(0, 2'b01, 0, 32'h12, 32'd0, 1);
        chk("lh_data", resp_rdata, 32'hFFFF_A000);
        issue(0, 2'b01, 1, 32'h12, 32'd0, 1);
        chk("lhu_data", resp_rdata, 32'h0000_A000);
        issue(1, 2'b00, 0, 32'h11, 32'h1234_563C, 1);
        chk("sb_addr", mem_addr, 32'h10);
        chk("sb_wdata", mem_wdata, 32'hA000_3CF5);
        issue(0, 2'b10, 0, 32'h10, 32'd0, 1);
        chk("lw_after_sb", resp_rdata, 32'hA000_3CF5);
        issue(1, 2'b10, 0, 32'h14, 32'hDEAD_BEEF, 1);
        chk("sw_valid", 32'(resp_valid), 32'd1);
        issue(0, 2'b10, 0, 32'h14, 32'd0, 1);
        chk("lw_b2b", resp_rdata, 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 32'h12, 32'd0, 1);
`ifdef MISALIGN_CHECK_EN
        chk("lw_misalign_err", 32'(misalign_err), 32'd1);
`else
        @(negedge clock); #2;
        @(negedge clock); #2;
        chk("lw_unaligned", resp_rdata, 32'hA000_3CF5);
`endif

        // Reset while the half store is in its capture cycle.
        @(negedge clock); #2;
        saved = ref_mem[4];
        issue(1, 2'b01, 0, 32'h10, 32'h0000_7777, 0);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_rdata", resp_rdata, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        exp_rv.delete();
        exp_mw.delete();
        exp_err.delete();
        exp_ma.delete();
        exp_md.delete();
        exp_rd.delete();
        cur_rd = 32'd0;
        busy_until = 0;
        ref_mem[4] = saved;
        @(negedge clock); #2;
        reset = 1'b0;
        chk("abort_mem_word", dmem[4], 32'hA000_3CF5);
        @(negedge clock); #2;
        issue(0, 2'b10, 0, 32'h10, 32'd0, 1);
        chk("abort_lw", resp_rdata, 32'hA000_3CF5);

        for (int k = 0; k < 300; k++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom),
                  32'($urandom_range(0, 63)), $urandom, 1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock); #2;
            end
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 16; i++)
            chk("final_mem", dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
